// File: rtl/mod3_check_scheduler.sv
// Round-robin front end sharing one bit-serial mod-3 residue engine among NUM_REQ requesters.
// Words are shifted MSB-first through r <= (2r+b) mod 3 and returned with the requester id.
module mod3_check_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic                     abort,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [1:0]               rsp_residue,
  output logic                     rsp_div3,
  output logic                     busy,
  output logic [15:0]              div_count
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ID_W-1:0]   r_last;
  logic [ID_W-1:0]   w_gnt;
  logic              w_any;
  logic              w_accept;
  logic              w_last_bit;
  logic              w_deliver;
  logic [WIDTH-1:0]  w_sel;
  logic [WIDTH-1:0]  r_shift;
  logic [1:0]        r_res;
  logic [1:0]        w_res_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_rsp_valid;
  logic [ID_W-1:0]   r_rsp_id;
  logic [1:0]        r_rsp_res;
  logic              r_rsp_div3;
  logic [15:0]       r_div_count;

  function automatic logic [1:0] mod3_step(input logic [1:0] r, input logic b);
    case (r)
      2'd0:    mod3_step = b ? 2'd1 : 2'd0;
      2'd1:    mod3_step = b ? 2'd0 : 2'd2;
      default: mod3_step = b ? 2'd2 : 2'd1;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Rotating-priority search starting just after the last grant; the nearest hit wins.
  always_comb begin : p_grant
    logic [ID_W-1:0] w_idx;
    w_gnt = r_last;
    w_any = 1'b0;
    w_idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = ID_W'((int'(r_last) + k) % NUM_REQ);
      if (req_valid[w_idx]) begin
        w_gnt = w_idx;
        w_any = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == w_gnt) w_sel = req_data[i*WIDTH +: WIDTH];
    end
  end

  assign w_accept   = (r_state == IDLE) && !abort && w_any;
  assign w_last_bit = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_deliver  = (r_state == DONE) && !abort && rsp_ready;
  assign w_res_nxt  = mod3_step(r_res, r_shift[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = SHIFT;
      SHIFT: begin
        if (abort)           w_next = IDLE;
        else if (w_last_bit) w_next = DONE;
      end
      DONE:    if (abort || rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // req_ready is gated by rst_n so nothing is offered while reset is held.
  always_comb begin
    req_ready = '0;
    busy      = (r_state != IDLE);
    if (rst_n && w_accept) req_ready[w_gnt] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last      <= ID_W'(NUM_REQ - 1);
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_res   <= 2'd0;
      r_rsp_div3  <= 1'b0;
      r_div_count <= 16'd0;
    end else begin
      if (w_accept) begin
        r_last   <= w_gnt;
        r_rsp_id <= w_gnt;
        r_cnt    <= '0;
      end
      if ((r_state == SHIFT) && !abort) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_last_bit) begin
          r_rsp_valid <= 1'b1;
          r_rsp_res   <= w_res_nxt;
          r_rsp_div3  <= (w_res_nxt == 2'd0);
        end
      end
      if ((r_state != IDLE) && abort) r_rsp_valid <= 1'b0;
      if (w_deliver) begin
        r_rsp_valid <= 1'b0;
        if (r_rsp_div3) r_div_count <= sat_inc(r_div_count);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_shift <= w_sel;
      r_res   <= 2'd0;
    end else if (r_state == SHIFT) begin
      r_shift <= r_shift << 1;
      r_res   <= w_res_nxt;
    end
  end

  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_residue = r_rsp_res;
  assign rsp_div3    = r_rsp_div3;
  assign div_count   = r_div_count;

endmodule

// File: tb/tb_mod3_check_scheduler.sv
// Directed bench for mod3_check_scheduler: arbitration, residues, latency, backpressure,
// abort, mid-operation reset and div_count saturation.
`timescale 1ns/1ps
module tb_mod3_check_scheduler;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int ID_W    = 2;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic                     abort = 1'b0;
  logic                     rsp_valid;
  logic                     rsp_ready = 1'b1;
  logic [ID_W-1:0]          rsp_id;
  logic [1:0]               rsp_residue;
  logic                     rsp_div3;
  logic                     busy;
  logic [15:0]              div_count;
  logic [WIDTH-1:0]         word [NUM_REQ];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int exp_div = 0;

  assign req_data = {word[3], word[2], word[1], word[0]};

  mod3_check_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .abort(abort), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_residue(rsp_residue), .rsp_div3(rsp_div3), .busy(busy),
    .div_count(div_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // Offer one word on requester r, wait for its grant, then wait for the result.
  // lat is the number of cycles from the handshake cycle to the first rsp_valid cycle.
  task automatic do_word(input logic [1:0] r, input logic [7:0] d, output int lat, output bit ok);
    @(negedge clk);
    word[r] = d;
    req_valid = 4'b0001 << r;
    #1;
    ok = 1'b0;
    lat = 0;
    for (int k = 0; k < 20 && !req_ready[r]; k++) begin
      @(negedge clk); #1;
    end
    if (req_ready[r]) begin
      @(negedge clk);
      req_valid = '0;
      lat = 1;
      #1;
      while (!rsp_valid && lat < 40) begin
        @(negedge clk); lat++; #1;
      end
      ok = rsp_valid;
    end else begin
      req_valid = '0;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; abort = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_div = 0;
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 40 && busy; k++) begin
      @(negedge clk); #1;
    end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_idle: busy got %b expected 0", name, busy); end
  endtask

  task automatic test_reset();
    int lat;
    rst_n = 1'b0; req_valid = 4'hF; rsp_ready = 1'b1; abort = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_chk++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready: got %b expected 0000", req_ready); end
    n_chk++; if ({rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL rst_valid_busy: got %b expected 00", {rsp_valid, busy}); end
    n_chk++; if ({rsp_id, rsp_residue, rsp_div3} !== 5'd0) begin n_fail++; $display("FAIL rst_rsp: got %b expected 00000", {rsp_id, rsp_residue, rsp_div3}); end
    n_chk++; if (div_count !== 16'd0) begin n_fail++; $display("FAIL rst_divcnt: got %h expected 0000", div_count); end
    @(negedge clk);
    word[0] = 8'h0F; req_valid = 4'b0001; rst_n = 1'b1;
    #1;
    n_chk++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL t1_grant: got %b expected 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    n_chk++; if ({req_ready, busy} !== 5'b00001) begin n_fail++; $display("FAIL t1_shift: ready/busy got %b expected 00001", {req_ready, busy}); end
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk); lat++; #1;
    end
    n_chk++; if (lat !== 9) begin n_fail++; $display("FAIL t1_latency: got %0d expected 9", lat); end
    n_chk++; if ({rsp_id, rsp_residue, rsp_div3} !== {2'd0, 2'd0, 1'b1}) begin n_fail++; $display("FAIL t1_rsp: id/res/div3 got %b expected 00001", {rsp_id, rsp_residue, rsp_div3}); end
    @(negedge clk); #1;
    exp_div = 1;
    n_chk++; if (div_count !== 16'(exp_div)) begin n_fail++; $display("FAIL t1_divcnt: got %0d expected %0d", div_count, exp_div); end
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL t1_rsp_clear: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_residues();
    logic [7:0] wv [4] = '{8'h0B, 8'h00, 8'hFF, 8'h80};
    logic [1:0] ev [4] = '{2'd2, 2'd0, 2'd0, 2'd2};
    int lat;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      do_word(2'd1, wv[i], lat, ok);
      n_chk++; if (!ok || lat != 9) begin n_fail++; $display("FAIL t2_lat%0d: got %0d expected 9", i, lat); end
      n_chk++; if (rsp_id !== 2'd1) begin n_fail++; $display("FAIL t2_id%0d: got %0d expected 1", i, rsp_id); end
      n_chk++; if (rsp_residue !== ev[i]) begin n_fail++; $display("FAIL t2_res%0d: got %0d expected %0d", i, rsp_residue, ev[i]); end
      n_chk++; if (rsp_div3 !== (ev[i] == 2'd0)) begin n_fail++; $display("FAIL t2_div3_%0d: got %b expected %b", i, rsp_div3, (ev[i] == 2'd0)); end
      if (ev[i] == 2'd0) exp_div++;
    end
    @(negedge clk); #1;
    n_chk++; if (div_count !== 16'(exp_div)) begin n_fail++; $display("FAIL t2_divcnt: got %0d expected %0d", div_count, exp_div); end
  endtask

  task automatic test_round_robin();
    int gid [5];
    int gcyc [5];
    logic [1:0] rid [4];
    logic [1:0] rres [4];
    logic [1:0] eres [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    int eg [5] = '{0, 1, 2, 3, 0};
    int ng = 0;
    int nr = 0;
    apply_reset();
    @(negedge clk);
    word[0] = 8'd3; word[1] = 8'd4; word[2] = 8'd5; word[3] = 8'd6;
    req_valid = 4'hF;
    for (int k = 0; k < 80 && ng < 5; k++) begin
      #1;
      if (req_ready != '0) begin
        n_chk++; if (!$onehot(req_ready)) begin n_fail++; $display("FAIL t3_onehot: got %b expected one-hot", req_ready); end
        for (int j = 0; j < NUM_REQ; j++) if (req_ready[j]) gid[ng] = j;
        gcyc[ng] = cyc;
        ng++;
      end
      if (rsp_valid && nr < 4) begin
        rid[nr] = rsp_id; rres[nr] = rsp_residue; nr++;
      end
      @(negedge clk);
    end
    req_valid = '0;
    n_chk++; if (ng !== 5 || nr !== 4) begin n_fail++; $display("FAIL t3_count: grants/rsps got %0d/%0d expected 5/4", ng, nr); end
    for (int i = 0; i < 5 && i < ng; i++) begin
      n_chk++; if (gid[i] !== eg[i]) begin n_fail++; $display("FAIL t3_order%0d: got %0d expected %0d", i, gid[i], eg[i]); end
      if (i > 0) begin
        n_chk++; if (gcyc[i] - gcyc[i-1] !== 10) begin n_fail++; $display("FAIL t3_interval%0d: got %0d expected 10", i, gcyc[i] - gcyc[i-1]); end
      end
    end
    for (int i = 0; i < 4 && i < nr; i++) begin
      n_chk++; if ({rid[i], rres[i]} !== {2'(i), eres[i]}) begin n_fail++; $display("FAIL t3_rsp%0d: id/res got %0d/%0d expected %0d/%0d", i, rid[i], rres[i], i, eres[i]); end
    end
    wait_idle("t3");
    exp_div += 3;
    n_chk++; if (div_count !== 16'(exp_div)) begin n_fail++; $display("FAIL t3_divcnt: got %0d expected %0d", div_count, exp_div); end
  endtask

  task automatic test_backpressure();
    int lat;
    bit ok;
    rsp_ready = 1'b0;
    word[3] = 8'h01;
    do_word(2'd2, 8'h07, lat, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL t4_rsp: rsp_valid got 0 expected 1"); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req_valid = 4'hF;
      #1;
      n_chk++; if ({rsp_valid, rsp_id, rsp_residue, rsp_div3, busy} !== {1'b1, 2'd2, 2'd1, 1'b0, 1'b1}) begin
        n_fail++; $display("FAIL t4_hold%0d: v/id/res/div3/busy got %b expected 1100101", k, {rsp_valid, rsp_id, rsp_residue, rsp_div3, busy});
      end
      n_chk++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL t4_noready%0d: got %b expected 0000", k, req_ready); end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    n_chk++; if ({busy, rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL t4_exit: busy/valid got %b expected 00", {busy, rsp_valid}); end
    n_chk++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL t4_next_grant: got %b expected 1000", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    wait_idle("t4");
    n_chk++; if (div_count !== 16'(exp_div)) begin n_fail++; $display("FAIL t4_divcnt: got %0d expected %0d", div_count, exp_div); end
  endtask

  task automatic test_abort_and_reset();
    bit seen;
    word[2] = 8'h09; word[3] = 8'h02; word[0] = 8'h0F;
    @(negedge clk);
    req_valid = 4'b0100;
    #1;
    for (int k = 0; k < 20 && !req_ready[2]; k++) begin @(negedge clk); #1; end
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    abort = 1'b1; req_valid = 4'b1100;
    #1;
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t5_in_shift: busy got %b expected 1", busy); end
    @(negedge clk); #1;
    n_chk++; if ({busy, rsp_valid, req_ready} !== 6'b000000) begin n_fail++; $display("FAIL t5_abort_idle: busy/valid/ready got %b expected 000000", {busy, rsp_valid, req_ready}); end
    @(negedge clk);
    abort = 1'b0;
    #1;
    n_chk++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL t5_after_abort_grant: got %b expected 1000", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (rsp_valid) seen = 1'b1;
      else begin @(negedge clk); #1; end
    end
    n_chk++; if ({seen, rsp_id, rsp_residue} !== {1'b1, 2'd3, 2'd2}) begin n_fail++; $display("FAIL t5_req3_rsp: seen/id/res got %b expected 11110", {seen, rsp_id, rsp_residue}); end
    n_chk++; if (div_count !== 16'(exp_div)) begin n_fail++; $display("FAIL t5_divcnt: got %0d expected %0d", div_count, exp_div); end
    @(negedge clk);
    word[2] = 8'h0C;
    req_valid = 4'b0100;
    #1;
    for (int k = 0; k < 20 && !req_ready[2]; k++) begin @(negedge clk); #1; end
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0; req_valid = 4'hF;
    #1;
    exp_div = 0;
    n_chk++; if ({busy, rsp_valid, rsp_id, rsp_residue, rsp_div3, req_ready} !== 11'd0) begin
      n_fail++; $display("FAIL t5_rst_outputs: got %b expected all zero", {busy, rsp_valid, rsp_id, rsp_residue, rsp_div3, req_ready});
    end
    n_chk++; if (div_count !== 16'd0) begin n_fail++; $display("FAIL t5_rst_divcnt: got %0d expected 0", div_count); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_chk++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL t5_rst_first_grant: got %b expected 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    wait_idle("t5");
    exp_div = 1;
    n_chk++; if (div_count !== 16'(exp_div)) begin n_fail++; $display("FAIL t5_post_rst_divcnt: got %0d expected %0d", div_count, exp_div); end
  endtask

  task automatic test_saturation();
    int lat;
    bit ok;
    @(negedge clk);
    force dut.r_div_count = 16'hFFFE;
    @(negedge clk);
    release dut.r_div_count;
    #1;
    n_chk++; if (div_count !== 16'hFFFE) begin n_fail++; $display("FAIL t6_preload: got %h expected fffe", div_count); end
    do_word(2'd1, 8'h03, lat, ok);
    @(negedge clk); #1;
    n_chk++; if (div_count !== 16'hFFFF) begin n_fail++; $display("FAIL t6_reach_max: got %h expected ffff", div_count); end
    do_word(2'd1, 8'h06, lat, ok);
    n_chk++; if (!ok || rsp_div3 !== 1'b1) begin n_fail++; $display("FAIL t6_div3: got %b expected 1", rsp_div3); end
    @(negedge clk); #1;
    n_chk++; if (div_count !== 16'hFFFF) begin n_fail++; $display("FAIL t6_saturate: got %h expected ffff", div_count); end
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) word[i] = '0;
    test_reset();
    test_residues();
    test_round_robin();
    test_backpressure();
    test_abort_and_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
